// File: rtl/axi_rdata_xbar_if.sv
// R-channel bundle of axi_rdata_xbar: slave-side ports (_S) and master-side ports (_M).
// The crossbar takes the "master" modport and the environment takes "slave".
interface axi_rdata_xbar_if #(
    parameter int NUM_SLAVES  = 3,
    parameter int NUM_MASTERS = 2,
    parameter int ID_BITS     = 4,
    parameter int IDS_BITS    = 8,
    parameter int DATA_BITS   = 32
);
    logic [NUM_SLAVES*IDS_BITS-1:0]    RID_S;
    logic [NUM_SLAVES*DATA_BITS-1:0]   RDATA_S;
    logic [NUM_SLAVES*2-1:0]           RRESP_S;
    logic [NUM_SLAVES-1:0]             RLAST_S;
    logic [NUM_SLAVES-1:0]             RVALID_S;
    logic [NUM_SLAVES-1:0]             RREADY_S;
    logic [NUM_MASTERS*ID_BITS-1:0]    RID_M;
    logic [NUM_MASTERS*DATA_BITS-1:0]  RDATA_M;
    logic [NUM_MASTERS*2-1:0]          RRESP_M;
    logic [NUM_MASTERS-1:0]            RLAST_M;
    logic [NUM_MASTERS-1:0]            RVALID_M;
    logic [NUM_MASTERS-1:0]            RREADY_M;

    modport master (
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        output RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );

    modport slave (
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
        input  RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
    );
endinterface

// File: rtl/axi_rdata_xbar.sv
// AXI R-channel crossbar: round-robin slave arbitration locked per burst, one-hot master routing,
// drain of undecodable beats. Optional 2-entry output skid buffer under macro RDATA_REG_SLICE_EN.
module axi_rdata_xbar #(
    parameter int NUM_SLAVES  = 3,
    parameter int NUM_MASTERS = 2,
    parameter int ID_BITS     = 4,
    parameter int IDS_BITS    = 8,
    parameter int DATA_BITS   = 32
) (
    input  logic              clk,
    input  logic              rst,
    axi_rdata_xbar_if.master  bus,
    output logic [15:0]       drop_cnt
);
    localparam int PTR_BITS  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int MIDX_BITS = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SEL_BITS  = IDS_BITS - ID_BITS;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [PTR_BITS-1:0]    grant_r, grant_s, ptr_r, ptr_s, pick_s, gnt_s;
    logic [15:0]            drop_r, drop_s;
    logic                   found_s, act_s, route_s, up_ready_s, m_rdy_s, hs_s;
    logic [MIDX_BITS-1:0]   mst_s;
    logic [IDS_BITS-1:0]    g_id_s;
    logic [DATA_BITS-1:0]   g_data_s;
    logic [1:0]             g_resp_s;
    logic                   g_last_s, g_valid_s;
    logic [MIDX_BITS:0]     dec_s;

    // Returns {routable, master index}; zero, multi-hot or out-of-range selects are not routable
    function automatic logic [MIDX_BITS:0] decode_sel(input logic [SEL_BITS-1:0] sel);
        logic [MIDX_BITS:0] res;
        res = '0;
        if ($onehot(sel)) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (sel[k]) res = {1'b1, MIDX_BITS'(k)};
            end
        end else begin
            res = '0;
        end
        return res;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) r = v;
        else               r = v + 16'd1;
        return r;
    endfunction

    // Arbitration, granted-slave field selection and route decode
    always_comb begin
        int idx;
        found_s   = 1'b0;
        pick_s    = '0;
        idx       = 0;
        g_id_s    = '0;
        g_data_s  = '0;
        g_resp_s  = 2'b00;
        g_last_s  = 1'b0;
        g_valid_s = 1'b0;
        m_rdy_s   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            idx = (int'(ptr_r) + i) % NUM_SLAVES;
            if (!found_s && bus.RVALID_S[PTR_BITS'(idx)]) begin
                found_s = 1'b1;
                pick_s  = PTR_BITS'(idx);
            end else begin
                found_s = found_s;
            end
        end
        gnt_s = (state_r == ST_LOCKED) ? grant_r : pick_s;
        act_s = rst & ((state_r == ST_LOCKED) | found_s);
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (gnt_s == PTR_BITS'(s)) begin
                g_id_s    = bus.RID_S[s*IDS_BITS +: IDS_BITS];
                g_data_s  = bus.RDATA_S[s*DATA_BITS +: DATA_BITS];
                g_resp_s  = bus.RRESP_S[s*2 +: 2];
                g_last_s  = bus.RLAST_S[s];
                g_valid_s = bus.RVALID_S[s];
            end else begin
                g_valid_s = g_valid_s;
            end
        end
        dec_s   = decode_sel(g_id_s[IDS_BITS-1:ID_BITS]);
        route_s = dec_s[MIDX_BITS];
        mst_s   = dec_s[MIDX_BITS-1:0];
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (mst_s == MIDX_BITS'(k)) m_rdy_s = bus.RREADY_M[k];
            else                        m_rdy_s = m_rdy_s;
        end
        hs_s = act_s & g_valid_s & up_ready_s;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            bus.RREADY_S[s] = act_s & (gnt_s == PTR_BITS'(s)) & up_ready_s;
        end
    end

    // Burst lock, pointer advance and drain accounting
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        drop_s  = drop_r;
        if (act_s && hs_s && g_last_s) begin
            state_s = ST_IDLE;
            ptr_s   = (gnt_s == PTR_BITS'(NUM_SLAVES - 1)) ? '0 : gnt_s + PTR_BITS'(1);
        end else if (act_s) begin
            state_s = ST_LOCKED;
            grant_s = gnt_s;
        end else begin
            state_s = state_r;
        end
        if (hs_s && !route_s) drop_s = sat_inc(drop_r);
        else                  drop_s = drop_r;
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
            drop_r  <= 16'd0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
            drop_r  <= drop_s;
        end
    end

    assign drop_cnt = drop_r;

`ifdef RDATA_REG_SLICE_EN
    typedef struct packed {
        logic [MIDX_BITS-1:0] mst;
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } ent_t;

    ent_t       buf_r [2];
    ent_t       head_s;
    logic [1:0] cnt_r;
    logic       wr_r, rd_r, push_s, pop_s, head_rdy_s;

    // Slave-side acceptance depends only on occupancy, never on RREADY_M
    assign up_ready_s = route_s ? (cnt_r != 2'd2) : 1'b1;
    assign head_s     = buf_r[rd_r];
    assign push_s     = hs_s & route_s;
    assign pop_s      = (cnt_r != 2'd0) & head_rdy_s;

    // Ready of the master addressed by the buffer head
    always_comb begin
        head_rdy_s = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (head_s.mst == MIDX_BITS'(k)) head_rdy_s = bus.RREADY_M[k];
            else                             head_rdy_s = head_rdy_s;
        end
    end

    // Skid buffer storage and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= 2'd0;
            wr_r     <= 1'b0;
            rd_r     <= 1'b0;
            buf_r[0] <= '0;
            buf_r[1] <= '0;
        end else begin
            if (push_s) begin
                buf_r[wr_r] <= '{mst: mst_s, id: g_id_s[ID_BITS-1:0], data: g_data_s,
                                 resp: g_resp_s, last: g_last_s};
                wr_r        <= ~wr_r;
            end
            if (pop_s) rd_r <= ~rd_r;
            cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Master ports driven from the buffer head
    always_comb begin
        bus.RID_M    = '0;
        bus.RDATA_M  = '0;
        bus.RRESP_M  = '0;
        bus.RLAST_M  = '0;
        bus.RVALID_M = '0;
        if (rst && cnt_r != 2'd0) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                bus.RID_M[k*ID_BITS +: ID_BITS]       = head_s.id;
                bus.RDATA_M[k*DATA_BITS +: DATA_BITS] = head_s.data;
                bus.RRESP_M[k*2 +: 2]                 = head_s.resp;
                bus.RLAST_M[k]                        = head_s.last;
                bus.RVALID_M[k]                       = (head_s.mst == MIDX_BITS'(k));
            end
        end else begin
            bus.RVALID_M = '0;
        end
    end
`else
    assign up_ready_s = route_s ? m_rdy_s : 1'b1;

    // Master ports driven straight from the granted slave
    always_comb begin
        bus.RID_M    = '0;
        bus.RDATA_M  = '0;
        bus.RRESP_M  = '0;
        bus.RLAST_M  = '0;
        bus.RVALID_M = '0;
        if (act_s) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                bus.RID_M[k*ID_BITS +: ID_BITS]       = g_id_s[ID_BITS-1:0];
                bus.RDATA_M[k*DATA_BITS +: DATA_BITS] = g_data_s;
                bus.RRESP_M[k*2 +: 2]                 = g_resp_s;
                bus.RLAST_M[k]                        = g_last_s;
                bus.RVALID_M[k] = route_s & (mst_s == MIDX_BITS'(k)) & g_valid_s;
            end
        end else begin
            bus.RVALID_M = '0;
        end
    end
`endif
endmodule
